// File: rtl/dbram_arbiter.sv
`timescale 1ns/1ps
// dbram_arbiter: shares the single-port data BRAM between the CPU mem/wb stage and the NN accelerator DMA.
// Define DBRAM_ARB_PERF_EN to build the stall/wait performance counters; otherwise the perf ports read 0.
module dbram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_WAIT  = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              acc_req,
  input  logic              acc_wr,
  input  logic              acc_lock,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              acc_rvalid,
  output logic              bram_en,
  output logic              bram_wr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [31:0]       perf_cpu_stall_cnt,
  output logic [31:0]       perf_acc_wait_cnt
);
  localparam int WW   = $clog2(MAX_WAIT + 1);
  localparam int BW   = $clog2(MAX_BURST + 1);
  localparam int LAST = RD_LAT - 1;
  localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {ST_CPU = 1'b0, ST_ACC_BURST = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [WW-1:0] r_wait_cnt;
  logic [BW-1:0] r_burst_cnt;
  logic          r_relock_blk;
  logic          w_force;
  logic          w_cpu_gnt;
  logic          w_acc_gnt;
  logic          w_rd_push;
  logic          r_tag_vld_p [RD_LAT];
  logic          r_tag_own_p [RD_LAT];

  function automatic logic [WW-1:0] sat_inc_wait(input logic [WW-1:0] v);
    return (v >= WAIT_MAX) ? WAIT_MAX : v + WW'(1);
  endfunction

  assign w_force   = acc_req && (r_wait_cnt >= WAIT_MAX);
  assign w_rd_push = (w_cpu_gnt && !cpu_wr) || (w_acc_gnt && !acc_wr);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CPU;
    else     r_state <= w_state_nxt;
  end

  // Entering a burst is blocked for the first CPU-mode cycle after one ends.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CPU:
        if (w_acc_gnt && acc_lock && !r_relock_blk && (MAX_BURST > 1))
          w_state_nxt = ST_ACC_BURST;
      ST_ACC_BURST:
        if (!acc_lock || (w_acc_gnt && (r_burst_cnt >= BURST_LAST)))
          w_state_nxt = ST_CPU;
      default: w_state_nxt = ST_CPU;
    endcase
  end

  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_acc_gnt  = 1'b0;
    bram_wr    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    if (!rst) begin
      if (r_state == ST_ACC_BURST) begin
        w_acc_gnt = acc_req;
      end else begin
        w_cpu_gnt = cpu_en && !w_force;
        w_acc_gnt = acc_req && !w_cpu_gnt;
      end
    end
    if (w_cpu_gnt) begin
      bram_wr    = cpu_wr;
      bram_addr  = cpu_addr;
      bram_wdata = cpu_wdata;
    end else if (w_acc_gnt) begin
      bram_wr    = acc_wr;
      bram_addr  = acc_addr;
      bram_wdata = acc_wdata;
    end
    bram_en   = w_cpu_gnt || w_acc_gnt;
    cpu_stall = cpu_en && !w_cpu_gnt;
    acc_gnt   = w_acc_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_relock_blk <= 1'b0;
    end else begin
      r_wait_cnt <= (w_acc_gnt || !acc_req) ? '0 : sat_inc_wait(r_wait_cnt);
      if (r_state == ST_CPU)
        r_burst_cnt <= (w_state_nxt == ST_ACC_BURST) ? BW'(1) : '0;
      else if (w_acc_gnt)
        r_burst_cnt <= r_burst_cnt + BW'(1);
      r_relock_blk <= (r_state == ST_ACC_BURST) && (w_state_nxt == ST_CPU);
    end
  end

  // Tag pipeline p0..p(RD_LAT-1): stage LAST lines up with bram_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_vld_p[i] <= 1'b0;
        r_tag_own_p[i] <= 1'b0;
      end
    end else begin
      r_tag_vld_p[0] <= w_rd_push;
      r_tag_own_p[0] <= w_acc_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld_p[i] <= r_tag_vld_p[i-1];
        r_tag_own_p[i] <= r_tag_own_p[i-1];
      end
    end
  end

  assign cpu_rvalid = !rst && r_tag_vld_p[LAST] && !r_tag_own_p[LAST];
  assign acc_rvalid = !rst && r_tag_vld_p[LAST] &&  r_tag_own_p[LAST];
  assign cpu_rdata  = cpu_rvalid ? bram_rdata : '0;
  assign acc_rdata  = acc_rvalid ? bram_rdata : '0;

`ifdef DBRAM_ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_wait  <= '0;
    end else begin
      if (cpu_stall)             r_perf_stall <= r_perf_stall + 32'd1;
      if (acc_req && !w_acc_gnt) r_perf_wait  <= r_perf_wait + 32'd1;
    end
  end

  assign perf_cpu_stall_cnt = r_perf_stall;
  assign perf_acc_wait_cnt  = r_perf_wait;
`else
  assign perf_cpu_stall_cnt = '0;
  assign perf_acc_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_dbram_arbiter.sv
`timescale 1ns/1ps
// Bench for dbram_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_dbram_arbiter;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int RD_LAT    = 2;
  localparam int MAX_WAIT  = 8;
  localparam int MAX_BURST = 16;
  localparam int VW        = 6 + ADDR_W + 3*DATA_W + 64;
`ifdef DBRAM_ARB_PERF_EN
  localparam logic [31:0] PERF_STALL_EXP = 32'd5;
`else
  localparam logic [31:0] PERF_STALL_EXP = 32'd0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cpu_en, cpu_wr, cpu_stall, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              acc_req, acc_wr, acc_lock, acc_gnt, acc_rvalid;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata, acc_rdata;
  logic              bram_en, bram_wr;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata, bram_rdata;
  logic [31:0]       perf_cpu_stall_cnt, perf_acc_wait_cnt;

  dbram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
                  .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .acc_req(acc_req), .acc_wr(acc_wr), .acc_lock(acc_lock), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
    .bram_en(bram_en), .bram_wr(bram_wr), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata),
    .perf_cpu_stall_cnt(perf_cpu_stall_cnt), .perf_acc_wait_cnt(perf_acc_wait_cnt)
  );

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i == 16) return 16'hBEEF;
    return DATA_W'((i * 40503) ^ 23130);
  endfunction

  // BRAM: 256 words aliased on addr[7:0]; non-read cycles return junk to expose ungated rdata.
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (bram_en && bram_wr) begin
      mem[bram_addr[7:0]] <= bram_wdata;
    end
    rd_pipe[0] <= (bram_en && !bram_wr) ? mem[bram_addr[7:0]] : DATA_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rdata = rd_pipe[RD_LAT-1];

  // Reference model
  typedef struct { int due; bit own; logic [DATA_W-1:0] data; } ret_t;
  ret_t rq[$];
  logic [DATA_W-1:0] smem [256];
  int  cyc, m_wait, m_bcnt;
  bit  m_burst, m_blk;
  logic [31:0] m_pstall, m_pwait;
  logic e_cpu_gnt, e_acc_gnt, e_stall, e_en, e_wr, e_crv, e_arv;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_crd, e_ard;
  logic [31:0] e_pstall, e_pwait;
  int n_vec, n_err;

  function automatic logic [VW-1:0] obs_vec();
    return {cpu_stall, acc_gnt, bram_en, bram_wr, bram_addr, bram_wdata, cpu_rvalid, cpu_rdata,
            acc_rvalid, acc_rdata, perf_cpu_stall_cnt, perf_acc_wait_cnt};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_stall, e_acc_gnt, e_en, e_wr, e_addr, e_wdata, e_crv, e_crd,
            e_arv, e_ard, e_pstall, e_pwait};
  endfunction

  task automatic model_eval();
    e_cpu_gnt = 1'b0;
    e_acc_gnt = 1'b0;
    if (!rst) begin
      if (m_burst)                            e_acc_gnt = acc_req;
      else if (acc_req && m_wait == MAX_WAIT) e_acc_gnt = 1'b1;
      else if (cpu_en)                        e_cpu_gnt = 1'b1;
      else                                    e_acc_gnt = acc_req;
    end
    e_stall = cpu_en && !e_cpu_gnt;
    e_en = e_cpu_gnt || e_acc_gnt;
    e_wr = 1'b0; e_addr = '0; e_wdata = '0;
    if (e_cpu_gnt) begin e_wr = cpu_wr; e_addr = cpu_addr; e_wdata = cpu_wdata; end
    else if (e_acc_gnt) begin e_wr = acc_wr; e_addr = acc_addr; e_wdata = acc_wdata; end
    e_crv = 1'b0; e_crd = '0; e_arv = 1'b0; e_ard = '0;
    if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].own) begin e_arv = 1'b1; e_ard = rq[0].data; end
      else           begin e_crv = 1'b1; e_crd = rq[0].data; end
    end
`ifdef DBRAM_ARB_PERF_EN
    e_pstall = m_pstall; e_pwait = m_pwait;
`else
    e_pstall = '0; e_pwait = '0;
`endif
  endtask

  task automatic model_commit();
    ret_t r;
    if (rst) begin
      m_burst = 0; m_blk = 0; m_wait = 0; m_bcnt = 0;
      m_pstall = '0; m_pwait = '0;
      rq.delete();
      for (int i = 0; i < 256; i++) smem[i] = init_word(i);
    end else begin
      if (rq.size() > 0 && rq[0].due == cyc) rq.delete(0);
      if (e_en) begin
        if (e_wr) smem[e_addr[7:0]] = e_wdata;
        else begin
          r.due = cyc + RD_LAT; r.own = e_acc_gnt; r.data = smem[e_addr[7:0]];
          rq.push_back(r);
        end
      end
      if (e_stall) m_pstall = m_pstall + 32'd1;
      if (acc_req && !e_acc_gnt) m_pwait = m_pwait + 32'd1;
      if (e_acc_gnt || !acc_req) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (m_burst) begin
        if (e_acc_gnt) m_bcnt++;
        if (!acc_lock || m_bcnt >= MAX_BURST) begin m_burst = 0; m_blk = 1; end
      end else begin
        if (e_acc_gnt && acc_lock && !m_blk && MAX_BURST > 1) begin m_burst = 1; m_bcnt = 1; end
        m_blk = 0;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    cpu_en = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    acc_req = 1'b0; acc_wr = 1'b0; acc_lock = 1'b0; acc_addr = '0; acc_wdata = '0;
  endtask

  task automatic rand_payload();
    cpu_wr = 1'($urandom_range(1)); cpu_addr = ADDR_W'($urandom); cpu_wdata = DATA_W'($urandom);
    acc_wr = 1'($urandom_range(1)); acc_addr = ADDR_W'($urandom); acc_wdata = DATA_W'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rst = 1'b0;
      #1; model_eval();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_model cyc=%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      n_vec++;
      if ({cpu_stall, acc_gnt, bram_en, cpu_rvalid, acc_rvalid} !== 5'b0) begin
        n_err++; $display("FAIL reset_outputs cyc=%0d: got %b want 00000", cyc,
                          {cpu_stall, acc_gnt, bram_en, cpu_rvalid, acc_rvalid});
      end
      tick();
    end
  endtask

  task automatic test_cpu_read();
    for (int i = 0; i <= RD_LAT; i++) begin
      set_idle();
      if (i == 0) begin cpu_en = 1'b1; cpu_addr = 16'h0010; cpu_wdata = DATA_W'($urandom); end
      #1; model_eval();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL cpu_read_model cyc=%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        n_vec++;
        if ({bram_en, cpu_stall, bram_addr} !== {1'b1, 1'b0, 16'h0010}) begin
          n_err++; $display("FAIL cpu_read_issue: got en=%b stall=%b addr=%h want 1 0 0010",
                            bram_en, cpu_stall, bram_addr);
        end
      end else if (i == RD_LAT) begin
        n_vec++;
        if ({cpu_rvalid, cpu_rdata, acc_rvalid} !== {1'b1, 16'hBEEF, 1'b0}) begin
          n_err++; $display("FAIL cpu_read_return: got rv=%b rd=%h arv=%b want 1 beef 0",
                            cpu_rvalid, cpu_rdata, acc_rvalid);
        end
      end else begin
        n_vec++;
        if (cpu_rvalid !== 1'b0) begin
          n_err++; $display("FAIL cpu_read_early: got rvalid=%b want 0", cpu_rvalid);
        end
      end
      tick();
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i <= RD_LAT + 2; i++) begin
      set_idle();
      if (i == 0) begin cpu_en = 1'b1; cpu_addr = 16'h0001; end
      if (i == 1) begin acc_req = 1'b1; acc_addr = 16'h0002; end
      #1; model_eval();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL interleave_model cyc=%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (i == RD_LAT) begin
        n_vec++;
        if ({cpu_rvalid, cpu_rdata, acc_rvalid} !== {1'b1, init_word(1), 1'b0}) begin
          n_err++; $display("FAIL interleave_cpu: got %b %h %b want 1 %h 0",
                            cpu_rvalid, cpu_rdata, acc_rvalid, init_word(1));
        end
      end
      if (i == RD_LAT + 1) begin
        n_vec++;
        if ({acc_rvalid, acc_rdata, cpu_rvalid} !== {1'b1, init_word(2), 1'b0}) begin
          n_err++; $display("FAIL interleave_acc: got %b %h %b want 1 %h 0",
                            acc_rvalid, acc_rdata, cpu_rvalid, init_word(2));
        end
      end
      tick();
    end
  endtask

  task automatic test_contention();
    logic fa;
    for (int i = 0; i < 27; i++) begin
      set_idle();
      rand_payload();
      cpu_en = 1'b1; acc_req = 1'b1;
      fa = (i % 9 == 8);
      #1; model_eval();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL contention_model cyc=%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      n_vec++;
      if ({acc_gnt, cpu_stall} !== {fa, fa}) begin
        n_err++; $display("FAIL contention_pattern i=%0d: got gnt=%b stall=%b want %b %b",
                          i, acc_gnt, cpu_stall, fa, fa);
      end
      tick();
    end
  endtask

  task automatic test_burst();
    int run, first_run;
    run = 0; first_run = -1;
    for (int i = 0; i < 40; i++) begin
      set_idle();
      rand_payload();
      cpu_en = 1'b1; acc_req = 1'b1; acc_lock = 1'b1;
      #1; model_eval();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL burst_model cyc=%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (acc_gnt === 1'b1) run++;
      else begin
        if (run > 0 && first_run < 0) begin
          first_run = run;
          n_vec++;
          if ({cpu_stall, bram_en} !== 2'b01) begin
            n_err++; $display("FAIL burst_cpu_after: got stall=%b en=%b want 0 1", cpu_stall, bram_en);
          end
        end
        run = 0;
      end
      tick();
    end
    n_vec++;
    if (first_run != MAX_BURST) begin
      n_err++; $display("FAIL burst_length: got %0d want %0d", first_run, MAX_BURST);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 9; i++) begin
      set_idle();
      rst = 1'b0;
      if (i >= 2 && i <= 5) begin acc_req = 1'b1; acc_lock = 1'b1; acc_addr = ADDR_W'($urandom); end
      if (i >= 3 && i <= 6) cpu_en = 1'b1;
      if (i == 5) rst = 1'b1;
      if (i == 6) begin acc_req = 1'b1; acc_lock = 1'b1; end
      #1; model_eval();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rst_burst_model cyc=%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (i == 4) begin
        n_vec++;
        if ({acc_gnt, cpu_stall} !== 2'b11) begin
          n_err++; $display("FAIL rst_burst_owned: got gnt=%b stall=%b want 1 1", acc_gnt, cpu_stall);
        end
      end
      if (i == 6) begin
        n_vec++;
        if ({cpu_stall, acc_gnt, bram_en} !== 3'b001) begin
          n_err++; $display("FAIL rst_burst_cpu_first: got stall=%b gnt=%b en=%b want 0 0 1",
                            cpu_stall, acc_gnt, bram_en);
        end
      end
      if (i == 6 || i == 7) begin
        n_vec++;
        if ({cpu_rvalid, acc_rvalid} !== 2'b00) begin
          n_err++; $display("FAIL rst_burst_dropped i=%0d: got %b%b want 00", i, cpu_rvalid, acc_rvalid);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(99) == 0);
      cpu_en = ($urandom_range(9) < 6);
      acc_req = ($urandom_range(9) < 5);
      acc_lock = ($urandom_range(9) < 6);
      rand_payload();
      #1; model_eval();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_model cyc=%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_perf();
    for (int i = 0; i < 8; i++) begin
      set_idle();
      rst = (i == 0);
      if (i >= 1 && i <= 6) begin acc_req = 1'b1; acc_lock = 1'b1; end
      if (i >= 2 && i <= 6) cpu_en = 1'b1;
      #1; model_eval();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL perf_model cyc=%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (i == 7) begin
        n_vec++;
        if ({perf_cpu_stall_cnt, perf_acc_wait_cnt} !== {PERF_STALL_EXP, 32'd0}) begin
          n_err++; $display("FAIL perf_counts: got stall=%0d wait=%0d want %0d 0",
                            perf_cpu_stall_cnt, perf_acc_wait_cnt, PERF_STALL_EXP);
        end
      end
      tick();
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    m_burst = 0; m_blk = 0; m_wait = 0; m_bcnt = 0; m_pstall = '0; m_pwait = '0;
    for (int i = 0; i < 256; i++) smem[i] = init_word(i);
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_interleave();
    test_contention();
    test_burst();
    test_reset_mid_burst();
    test_random();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dbram_arbiter.md
Name: dbram_arbiter

Overview:
Arbitrates the single-port data BRAM between the CPU mem/wb stage and the NN accelerator's DMA port. Sits between the CPU's mem_data_* interface, the accelerator, and the BRAM primitive. CPU has default priority. A starvation counter and a locked-burst mode give the accelerator bounded access latency. Read data returns to the issuing requester via a tag pipeline matched to BRAM latency.

Parameters:
ADDR_W, 16, BRAM address width
DATA_W, 16, BRAM data width
RD_LAT, 1, BRAM read latency in cycles (1..3)
MAX_WAIT, 8, accelerator wait cycles before forced grant (>=1)
MAX_BURST, 16, maximum consecutive locked accelerator grants (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_en  in  1  CPU access request (read or write)
cpu_wr  in  1  CPU write when 1
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_stall  out  1  CPU request not accepted this cycle; CPU holds request
cpu_rdata  out  DATA_W  CPU load data
cpu_rvalid  out  1  cpu_rdata valid
acc_req  in  1  accelerator request
acc_wr  in  1  accelerator write when 1
acc_lock  in  1  request burst ownership
acc_addr  in  ADDR_W  accelerator address
acc_wdata  in  DATA_W  accelerator write data
acc_gnt  out  1  accelerator request accepted this cycle
acc_rdata  out  DATA_W  accelerator read data
acc_rvalid  out  1  acc_rdata valid
bram_en  out  1  BRAM enable
bram_wr  out  1  BRAM write enable
bram_addr  out  ADDR_W  BRAM address
bram_wdata  out  DATA_W  BRAM write data
bram_rdata  in  DATA_W  BRAM read data

Behaviour:
- Clock clk, reset rst: one clock; reset synchronous, active-high.
- Single clock domain. All state updates on posedge clk. rst has priority over all other inputs.
- FSM states: ST_CPU (default), ST_ACC_BURST.
- ST_CPU: grant is combinational in the same cycle.
  - Grant CPU if cpu_en and wait_cnt < MAX_WAIT.
  - Otherwise grant acc if acc_req.
  - Forced grant: acc_req && wait_cnt==MAX_WAIT grants acc; cpu_stall=1 if cpu_en.
- wait_cnt:
  - Increments each cycle acc_req is high and not granted; saturates at MAX_WAIT.
  - Clears on any acc grant or when acc_req is low.
- ST_CPU -> ST_ACC_BURST: acc granted with acc_lock=1. burst_cnt loads 1.
- ST_ACC_BURST:
  - Acc has exclusive ownership; cpu_stall = cpu_en.
  - Each cycle acc_req is high: acc_gnt=1, burst_cnt++.
  - A cycle with acc_req low keeps ownership (bubble).
  - Exit to ST_CPU the cycle after acc_lock falls or burst_cnt reaches MAX_BURST. Acc cannot re-lock until at least one ST_CPU cycle has elapsed.
- Granted request drives bram_en=1 and bram_wr/addr/wdata from the winner the same cycle. With no grant, bram_en=0 and other bram_* outputs hold 0.
- cpu_stall = cpu_en && !cpu granted. acc_gnt = acc granted. Both are combinational.
- Read return:
  - Each granted read pushes a 2-bit tag {valid, owner} into an RD_LAT-deep shift register.
  - At the output end: cpu_rvalid/acc_rvalid = tag valid && owner match.
  - cpu_rdata/acc_rdata = bram_rdata when the matching rvalid is high, else 0.
  - Writes push an invalid tag.
- Reset values: state=ST_CPU, wait_cnt=0, burst_cnt=0, tag pipe cleared. All outputs are 0 except combinational outputs derived from inputs.
- Reset mid-burst: reads in flight are dropped (no rvalid); ownership returns to CPU.
- Simultaneous cpu_en and acc_req with wait_cnt<MAX_WAIT: CPU wins; wait_cnt increments.

Optional Feature:
DBRAM_ARB_PERF_EN
- Defined: adds 32-bit output perf_cpu_stall_cnt and 32-bit output perf_acc_wait_cnt.
  - Counters wrap on overflow.
  - Both clear on rst.
  - perf_cpu_stall_cnt increments each cycle cpu_stall=1.
  - perf_acc_wait_cnt increments each cycle acc_req && !acc_gnt.
- Undefined: ports still present, tied to 0; no counter logic.

Test Plan:
- CPU read addr 0x0010 (BRAM holds 0xBEEF), acc idle -> bram_en=1, no stall; cpu_rvalid=1 with cpu_rdata=0xBEEF exactly RD_LAT cycles later; acc_rvalid=0.
- cpu_en and acc_req both held high continuously, MAX_WAIT=8 -> CPU granted 8 cycles; cycle 9 acc_gnt=1 and cpu_stall=1; pattern repeats every 9 cycles.
- acc_lock=1 with acc_req high for 20 cycles, MAX_BURST=16, cpu_en high -> 16 consecutive acc_gnt; then CPU gets ≥1 grant before acc resumes.
- Interleaved CPU read 0x0001 and acc read 0x0002 on back-to-back cycles, RD_LAT=2 -> each rdata is routed only to the issuer with the correct value; no crossed rvalid.
- rst asserted for 1 cycle mid-burst with 2 reads in flight -> no rvalid afterwards; state=ST_CPU; next cpu_en is granted immediately.
- DBRAM_ARB_PERF_EN defined, 5 stalled CPU cycles -> perf_cpu_stall_cnt=5; undefined -> reads 0.
